// File: rtl/pwm_timer.sv
// Multi-channel PWM timer with a prescaled up-counter, shadowed period/compare
// registers, a wrap flag with interrupt and a single-cycle bus-slave handshake.
module pwm_timer #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                select,
  input  logic [3:0]          wstrb,
  input  logic [4:0]          addr,
  input  logic [31:0]         data_i,
  output logic                ready,
  output logic [31:0]         data_o,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam logic [11:0] CTRL_MASK =
    12'h003 | {4'((1 << CHANNELS) - 1), 4'((1 << CHANNELS) - 1), 4'h0};

  typedef enum logic [1:0] {BUS_IDLE, BUS_READY, BUS_HOLD} bus_state_t;

  bus_state_t          busState_q, busState_d;
  logic [11:0]         ctrl_q, ctrl_d;
  cnt_t                presc_q, presc_d;
  cnt_t                periodSh_q, periodSh_d;
  cnt_t                period_q, period_d;
  cnt_t                cmpSh_q [CHANNELS];
  cnt_t                cmpSh_d [CHANNELS];
  cnt_t                cmp_q [CHANNELS];
  cnt_t                cmp_d [CHANNELS];
  cnt_t                prescCnt_q, prescCnt_d;
  cnt_t                cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                irq_q, irq_d;

  logic                en, irqEn, tick, wrapEvt, wrEn, wrapClr, readyNow;
  logic [CHANNELS-1:0] chanEn, pol;
  logic [31:0]         wmask, rdata;

  function automatic logic [31:0] laneMerge(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [31:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  assign en     = ctrl_q[0];
  assign irqEn  = ctrl_q[1];
  assign chanEn = ctrl_q[4 +: CHANNELS];
  assign pol    = ctrl_q[8 +: CHANNELS];
  assign wmask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

  // BUS_HOLD keeps ready low until select drops, so one select assertion is one access.
  always_comb begin
    busState_d = busState_q;
    case (busState_q)
      BUS_IDLE:  if (select) busState_d = BUS_READY;
      BUS_READY: busState_d = select ? BUS_HOLD : BUS_IDLE;
      BUS_HOLD:  if (!select) busState_d = BUS_IDLE;
      default:   busState_d = BUS_IDLE;
    endcase
  end

  assign readyNow = (busState_q == BUS_READY);
  assign wrEn     = readyNow && (wstrb != 4'h0);
  assign tick     = en && (prescCnt_q >= presc_q);
  assign wrapEvt  = tick && (cnt_q >= period_q);
  assign wrapClr  = wrEn && (addr == 5'h0C) && wstrb[0] && data_i[0];

  always_comb begin
    rdata = '0;
    case (addr)
      5'h00:   rdata = 32'(ctrl_q);
      5'h04:   rdata = 32'(presc_q);
      5'h08:   rdata = 32'(periodSh_q);
      5'h0C:   rdata = {16'(cnt_q), 15'd0, wrap_q};
      default: begin
        for (int i = 0; i < CHANNELS; i++)
          if (addr == 5'(16 + 4 * i)) rdata = 32'(cmpSh_q[i]);
      end
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    presc_d    = presc_q;
    periodSh_d = periodSh_q;
    cmpSh_d    = cmpSh_q;
    if (wrEn) begin
      case (addr)
        5'h00:   ctrl_d = 12'(laneMerge(32'(ctrl_q), data_i, wmask)) & CTRL_MASK;
        5'h04:   presc_d = cnt_t'(laneMerge(32'(presc_q), data_i, wmask));
        5'h08:   periodSh_d = cnt_t'(laneMerge(32'(periodSh_q), data_i, wmask));
        default: begin
          for (int i = 0; i < CHANNELS; i++)
            if (addr == 5'(16 + 4 * i))
              cmpSh_d[i] = cnt_t'(laneMerge(32'(cmpSh_q[i]), data_i, wmask));
        end
      endcase
    end
  end

  // Shadows track continuously while stopped so a fresh enable starts on the written values.
  always_comb begin
    period_d   = period_q;
    cmp_d      = cmp_q;
    prescCnt_d = prescCnt_q + 1'b1;
    cnt_d      = cnt_q;
    if (!en || wrapEvt) begin
      period_d = periodSh_q;
      cmp_d    = cmpSh_q;
    end
    if (!en) begin
      prescCnt_d = '0;
      cnt_d      = '0;
    end else if (tick) begin
      prescCnt_d = '0;
      cnt_d      = wrapEvt ? '0 : cnt_q + 1'b1;
    end
    wrap_d = wrapEvt ? 1'b1 : (wrapClr ? 1'b0 : wrap_q);
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = ((cnt_q < cmp_q[i]) && chanEn[i] && en) ^ pol[i];
    irq_d = wrap_q && irqEn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busState_q <= BUS_IDLE;
      ctrl_q     <= '0;
      presc_q    <= '0;
      periodSh_q <= '0;
      period_q   <= '0;
      prescCnt_q <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      pwm_q      <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cmpSh_q[i] <= '0;
        cmp_q[i]   <= '0;
      end
    end else begin
      busState_q <= busState_d;
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      periodSh_q <= periodSh_d;
      period_q   <= period_d;
      prescCnt_q <= prescCnt_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      pwm_q      <= pwm_d;
      irq_q      <= irq_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cmpSh_q[i] <= cmpSh_d[i];
        cmp_q[i]   <= cmp_d[i];
      end
    end
  end

  assign ready   = readyNow;
  assign data_o  = readyNow ? rdata : 32'h0;
  assign pwm_out = pwm_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Directed self-checking bench for pwm_timer: register access, PWM waveform,
// shadow loading, duty boundaries, prescaler/IRQ, bus handshake and reset.
module tb_pwm_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        select;
  logic [3:0]  wstrb;
  logic [4:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic [3:0]  pwm_out;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int readyCyc = 0;

  pwm_timer #(.CHANNELS(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .pwm_out(pwm_out), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete bus access; inputs stay valid through the ready cycle so the write lands.
  task automatic applyStimulus(input logic [4:0] a, input logic [3:0] s,
                               input logic [31:0] d, output logic [31:0] rd);
    int n;
    @(negedge clk);
    select = 1'b1; addr = a; wstrb = s; data_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 8);
    checkOutput("bus ready", 32'(ready), 32'h1);
    rd = data_o;
    readyCyc = cyc;
    @(negedge clk);
    select = 1'b0; wstrb = 4'h0;
  endtask

  task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    applyStimulus(a, 4'hF, d, dummy);
  endtask

  task automatic busRead(input logic [4:0] a, output logic [31:0] rd);
    applyStimulus(a, 4'h0, 32'h0, rd);
  endtask

  task automatic waitRise0();
    int n = 0;
    while (pwm_out[0] !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    while (pwm_out[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic measureRun0(output int highLen, output int lowLen);
    waitRise0();
    highLen = 0;
    while (pwm_out[0] === 1'b1 && highLen < 40) begin @(negedge clk); highLen++; end
    lowLen = 0;
    while (pwm_out[0] === 1'b0 && lowLen < 40) begin @(negedge clk); lowLen++; end
  endtask

  task automatic waitIrq(output int atCyc);
    int n = 0;
    while (irq !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    atCyc = cyc;
  endtask

  initial begin
    logic [31:0] rd, got, exp;
    int hi, lo, rEn, irqCyc1, irqCyc2, pulses;
    logic or1, and2, and3, zeroBad;

    reset = 1'b1; select = 1'b0; wstrb = 4'h0; addr = 5'h0; data_i = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 32'(ready), 32'h0);
    checkOutput("reset data_o", data_o, 32'h0);
    checkOutput("reset irq", 32'(irq), 32'h0);
    checkOutput("reset pwm", 32'(pwm_out), 32'h0);
    reset = 1'b0;

    busRead(5'h00, rd);
    checkOutput("ctrl after reset", rd, 32'h0);
    busWrite(5'h00, 32'hFFFF_FFFE);
    busRead(5'h00, rd);
    checkOutput("ctrl field mask", rd, 32'h0000_0FF2);
    busWrite(5'h00, 32'h0);
    busWrite(5'h08, 32'h0000_1234);
    applyStimulus(5'h08, 4'b0001, 32'hFFFF_FF78, rd);
    busRead(5'h08, rd);
    checkOutput("period byte lane", rd, 32'h0000_1278);
    busWrite(5'h10, 32'h0000_0055);
    busWrite(5'h13, 32'hFFFF_FFFF);
    busRead(5'h13, rd);
    checkOutput("unmapped read", rd, 32'h0);
    busRead(5'h10, rd);
    checkOutput("unmapped write ignored", rd, 32'h0000_0055);

    // 10-clock period, channel 0 at 3/10, boundary channels 1..3, run enabled.
    busWrite(5'h04, 32'h0);
    busWrite(5'h08, 32'd9);
    busWrite(5'h10, 32'd3);
    busWrite(5'h14, 32'd0);
    busWrite(5'h18, 32'd10);
    busWrite(5'h00, 32'h0000_0871);
    measureRun0(hi, lo);
    checkOutput("pwm0 high 3", 32'(hi), 32'd3);
    checkOutput("pwm0 low 7", 32'(lo), 32'd7);

    or1 = 1'b0; and2 = 1'b1; and3 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      or1  = or1 | pwm_out[1];
      and2 = and2 & pwm_out[2];
      and3 = and3 & pwm_out[3];
    end
    checkOutput("pwm1 const 0", 32'(or1), 32'h0);
    checkOutput("pwm2 const 1", 32'(and2), 32'h1);
    checkOutput("pwm3 pol const 1", 32'(and3), 32'h1);

    // New compare written early in a period must not act before the next wrap.
    waitRise0();
    busWrite(5'h10, 32'd7);
    measureRun0(hi, lo);
    checkOutput("shadow high 7", 32'(hi), 32'd7);
    checkOutput("shadow low 3", 32'(lo), 32'd3);

    busWrite(5'h00, 32'h0);
    busRead(5'h0C, rd);
    checkOutput("status after disable", rd, 32'h0000_0001);
    busWrite(5'h0C, 32'h1);
    busRead(5'h0C, rd);
    checkOutput("wrap w1c", rd, 32'h0);

    // Prescale 4, period 2 counts: a wrap every 8 clocks.
    busWrite(5'h04, 32'd3);
    busWrite(5'h08, 32'd1);
    busWrite(5'h00, 32'h0000_0003);
    rEn = readyCyc;
    waitIrq(irqCyc1);
    checkOutput("irq first rise", 32'(irqCyc1 - rEn), 32'd10);
    busWrite(5'h0C, 32'h1);
    @(negedge clk);
    checkOutput("irq dropped", 32'(irq), 32'h0);
    waitIrq(irqCyc2);
    checkOutput("irq re-rise", 32'(irqCyc2 - irqCyc1), 32'd8);

    // Free-running counter, so STATUS[31:16] follows the cycle count after enable.
    busWrite(5'h00, 32'h0);
    busWrite(5'h0C, 32'h1);
    busWrite(5'h04, 32'h0);
    busWrite(5'h08, 32'h0000_FFFF);
    busWrite(5'h00, 32'h0000_0001);
    rEn = readyCyc;
    @(negedge clk);
    select = 1'b1; addr = 5'h0C; wstrb = 4'h0;
    pulses = 0; zeroBad = 1'b0; got = 32'h0; exp = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        got = data_o;
        exp = {16'(cyc - rEn - 1), 16'h0};
      end else if (data_o !== 32'h0) begin
        zeroBad = 1'b1;
      end
    end
    select = 1'b0;
    checkOutput("single ready pulse", 32'(pulses), 32'd1);
    checkOutput("status counter", got, exp);
    checkOutput("data_o zero idle", 32'(zeroBad), 32'h0);

    busWrite(5'h00, 32'h0);
    busWrite(5'h08, 32'd3);
    busWrite(5'h00, 32'h0000_0F03);
    repeat (12) @(negedge clk);
    checkOutput("running pwm pol", 32'(pwm_out), 32'hF);
    checkOutput("running irq", 32'(irq), 32'h1);
    select = 1'b1; addr = 5'h00; wstrb = 4'hF; data_i = 32'h0000_00F1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset ready", 32'(ready), 32'h0);
    checkOutput("mid reset data_o", data_o, 32'h0);
    checkOutput("mid reset irq", 32'(irq), 32'h0);
    checkOutput("mid reset pwm", 32'(pwm_out), 32'h0);
    reset = 1'b0; select = 1'b0; wstrb = 4'h0;
    @(negedge clk);
    busRead(5'h00, rd);
    checkOutput("ctrl after reset release", rd, 32'h0);
    busRead(5'h0C, rd);
    checkOutput("status after reset release", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
